// File: rtl/fpu_add_norm_round.sv
// Post-add normalize/round stage of the FP adder.
// Normalizes the raw big-ALU sum one bit per cycle, rounds to nearest-even,
// flushes denormals to zero and hands a packed IEEE-754 word downstream.
module fpu_add_norm_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [FRAC_W+4:0]       in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result,
  output logic                    out_ovf,
  output logic                    out_unf,
  output logic                    out_zero
);
  localparam int MW = FRAC_W + 5;
  // Exponent is carried one bit wider so increments/decrements never wrap.
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} stateE;

  stateE                 state, stateN;
  logic                  signR, signN;
  logic [EXP_W:0]        expR, expN;
  logic [MW-1:0]         mantR, mantN;
  logic [EXP_W+FRAC_W:0] resR, resN;
  logic                  ovfR, ovfN, unfR, unfN, zeroR, zeroN;

  // Rounding helpers: only the stored fraction is added to, since the hidden
  // bit is always set in ROUND, a carry out of the fraction is the mantissa carry.
  logic                  rndUp;
  logic [FRAC_W:0]       fracSum;
  logic [EXP_W:0]        expInc;

  // Held low while reset is asserted so upstream never sees a phantom accept.
  assign in_ready   = rst_n && (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_result = resR;
  assign out_ovf    = ovfR;
  assign out_unf    = unfR;
  assign out_zero   = zeroR;

  // Round-to-nearest-even increment and incremented exponent for ROUND.
  always_comb begin
    rndUp   = mantR[2] & (mantR[1] | mantR[0] | mantR[3]);
    fracSum = {1'b0, mantR[MW-3:3]} + {{FRAC_W{1'b0}}, rndUp};
    expInc  = expR + EXP_ONE;
  end

  // Next-state and datapath update, one normalization action per cycle.
  always_comb begin
    stateN = state;
    signN  = signR;
    expN   = expR;
    mantN  = mantR;
    resN   = resR;
    ovfN   = ovfR;
    unfN   = unfR;
    zeroN  = zeroR;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          signN = in_sign;
          expN  = {1'b0, in_exp};
          mantN = in_mant;
          ovfN  = 1'b0;
          unfN  = 1'b0;
          zeroN = 1'b0;
          if (&in_exp) begin
            // Inf/NaN: pass the fraction through untouched.
            resN   = {in_sign, in_exp, in_mant[MW-3:3]};
            stateN = DONE;
          end else begin
            stateN = NORM;
          end
        end
      end
      NORM: begin
        if (mantR == '0) begin
          resN   = '0;
          zeroN  = 1'b1;
          stateN = DONE;
        end else if (mantR[MW-1]) begin
          // Carry: shift right, folding the dropped bit into sticky.
          mantN = {1'b0, mantR[MW-1:2], mantR[1] | mantR[0]};
          expN  = expInc;
          if (expInc == EXP_MAX) begin
            resN   = {signR, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovfN   = 1'b1;
            stateN = DONE;
          end
        end else if (mantR[MW-2]) begin
          stateN = ROUND;
        end else if (expR <= EXP_ONE) begin
          // Would go denormal: flush to signed zero.
          resN   = {signR, {(EXP_W+FRAC_W){1'b0}}};
          unfN   = 1'b1;
          stateN = DONE;
        end else begin
          mantN = {mantR[MW-2:0], 1'b0};
          expN  = expR - EXP_ONE;
        end
      end
      ROUND: begin
        if (fracSum[FRAC_W]) begin
          resN = {signR, expInc[EXP_W-1:0], {FRAC_W{1'b0}}};
          expN = expInc;
          ovfN = (expInc == EXP_MAX);
        end else begin
          resN = {signR, expR[EXP_W-1:0], fracSum[FRAC_W-1:0]};
        end
        stateN = DONE;
      end
      DONE: begin
        if (out_ready) stateN = IDLE;
      end
      default: stateN = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      signR <= 1'b0;
      expR  <= '0;
      mantR <= '0;
      resR  <= '0;
      ovfR  <= 1'b0;
      unfR  <= 1'b0;
      zeroR <= 1'b0;
    end else begin
      state <= stateN;
      signR <= signN;
      expR  <= expN;
      mantR <= mantN;
      resR  <= resN;
      ovfR  <= ovfN;
      unfR  <= unfN;
      zeroR <= zeroN;
    end
  end
endmodule

// File: tb/tb_fpu_add_norm_round.sv
// Directed bench for fpu_add_norm_round: an arithmetic reference model feeds
// an expectation queue, a negedge monitor compares every valid output cycle.
module tb_fpu_add_norm_round;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_ovf, out_unf, out_zero;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf, unf, zero;
  } expT;
  expT expQ[$];

  fpu_add_norm_round #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference model: integer arithmetic on the value, not a step-by-step replay.
  function automatic void model(input logic sgn, input int e, input logic [27:0] m,
                                output expT x, output int cyc);
    int mm, ex, d, p, keep, rem;
    bit up, carry;
    x = '{res: 32'h0, ovf: 1'b0, unf: 1'b0, zero: 1'b0};
    carry = 1'b0;
    d = 0;
    if (e == 255) begin
      x.res = {sgn, 8'hFF, m[25:3]};
      cyc = 1;
      return;
    end
    if (m == 0) begin
      x.zero = 1'b1;
      cyc = 2;
      return;
    end
    mm = int'(m);
    ex = e;
    if (m[27]) begin
      carry = 1'b1;
      ex = e + 1;
      if (ex == 255) begin
        x.res = {sgn, 8'hFF, 23'h0};
        x.ovf = 1'b1;
        cyc = 2;
        return;
      end
      mm = (mm >> 1) | (mm & 1);
    end else begin
      p = 0;
      for (int i = 0; i < 28; i++) if (m[i]) p = i;
      d = 26 - p;
      if (e <= d) begin
        x.res = {sgn, 31'h0};
        x.unf = 1'b1;
        cyc = ((e > 1) ? e - 1 : 0) + 2;
        return;
      end
      mm = mm << d;
      ex = e - d;
    end
    keep = mm >> 3;
    rem  = mm & 7;
    up   = (rem > 4) || (rem == 4 && (keep % 2) == 1);
    keep = keep + (up ? 1 : 0);
    if (keep == (1 << 24)) begin
      ex = ex + 1;
      keep = 0;
    end
    if (ex == 255) begin
      x.res = {sgn, 8'hFF, 23'h0};
      x.ovf = 1'b1;
    end else begin
      x.res = {sgn, ex[7:0], keep[22:0]};
    end
    cyc = 3 + d + (carry ? 1 : 0);
  endfunction

  // Compare every cycle a result is presented; pop when it is being accepted.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got result %h want none", out_result);
      end else begin
        chk("result", out_result, expQ[0].res);
        chk("flags", {29'h0, out_ovf, out_unf, out_zero},
            {29'h0, expQ[0].ovf, expQ[0].unf, expQ[0].zero});
        if (out_ready) void'(expQ.pop_front());
      end
    end
  end

  task automatic runOp(input logic s, input logic [7:0] e, input logic [27:0] m, input int hold);
    expT x;
    int cyc, want;
    model(s, int'(e), m, x, want);
    begin
      int w = 0;
      while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    end
    chk("in_ready_idle", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    expQ.push_back(x);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sign = 1'($urandom); in_exp = 8'($urandom); in_mant = 28'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      chk("in_ready_busy", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1; cyc++;
    end
    chk("latency", cyc, want);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'h0, out_valid}, 32'h1);
      chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", {31'h0, out_valid}, 32'h0);
  endtask

  task automatic pin(input string name, input logic s, input logic [7:0] e, input logic [27:0] m,
                     input logic [31:0] res, input logic [2:0] fl, input int cy);
    expT x;
    int c;
    model(s, int'(e), m, x, c);
    chk({name, "_res"}, x.res, res);
    chk({name, "_flags"}, {29'h0, x.ovf, x.unf, x.zero}, {29'h0, fl});
    chk({name, "_cyc"}, c, cy);
  endtask

  initial begin
    // Pin the model against hand-derived values (flags = {ovf,unf,zero}).
    pin("m_norm",  0, 8'h7F, 28'h4000000, 32'h3F800000, 3'b000, 3);
    pin("m_carry", 0, 8'h7F, 28'h8000000, 32'h40000000, 3'b000, 4);
    pin("m_lshft", 0, 8'h80, 28'h0800000, 32'h3E800000, 3'b000, 6);
    pin("m_tie",   0, 8'h7F, 28'h400000C, 32'h3F800002, 3'b000, 3);
    pin("m_rovf",  0, 8'hFE, 28'h7FFFFFC, 32'h7F800000, 3'b100, 3);
    pin("m_pass",  0, 8'hFF, 28'h4000008, 32'h7F800001, 3'b000, 1);
    pin("m_unf",   1, 8'h01, 28'h2000000, 32'h80000000, 3'b010, 2);
    pin("m_stky",  0, 8'h7F, 28'h8000009, 32'h40000001, 3'b000, 4);

    // Reset state.
    #12;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_flags", {29'h0, out_ovf, out_unf, out_zero}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'h0, in_ready}, 32'h1);

    runOp(0, 8'h7F, 28'h4000000, 0);
    runOp(0, 8'h7F, 28'h8000000, 0);
    runOp(0, 8'h80, 28'h0800000, 0);
    runOp(0, 8'h7F, 28'h4000004, 0);
    runOp(0, 8'h7F, 28'h400000C, 0);
    runOp(0, 8'h7F, 28'h4000006, 0);
    runOp(0, 8'hFE, 28'h7FFFFFC, 0);
    runOp(0, 8'hFF, 28'h4000008, 0);
    runOp(1, 8'h55, 28'h0000000, 0);
    runOp(1, 8'h01, 28'h2000000, 0);
    runOp(1, 8'h7F, 28'h8000009, 0);
    runOp(0, 8'hFE, 28'h8000000, 0);
    runOp(1, 8'h03, 28'h0100000, 0);
    runOp(1, 8'h90, 28'h0000001, 0);
    runOp(1, 8'h85, 28'h5A5A5A7, 5);

    // Reset while normalizing aborts the op.
    in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'h80; in_mant = 28'h0800000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'h0, out_valid}, 32'h0);
    chk("abort_in_ready", {31'h0, in_ready}, 32'h0);
    chk("abort_result", out_result, 32'h0);
    chk("abort_flags", {29'h0, out_ovf, out_unf, out_zero}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      chk("abort_idle", {31'h0, out_valid}, 32'h0);
    end
    runOp(0, 8'h7F, 28'h4000000, 0);

    repeat (3) @(posedge clk);
    chk("queue_empty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
